aes_inv_cipher: RTL and testbench

- Iterative AES-128 inverse cipher (decryption). Counterpart to the existing forward AES_Cipher.
- Takes a 128-bit ciphertext and the full expanded key schedule produced by the existing KeyExpansion block. Returns the 128-bit plaintext.
- Executes one inverse round per clock cycle, using valid/ready handshakes on both the input side and the output side.

---
 rtl/aes_pkg.sv | 146 ++++++++++++++
 rtl/aes_inv_round.sv | 17 +
 rtl/aes_inv_cipher.sv | 109 ++++++++++
 tb/tb_aes_inv_cipher.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, S-boxes and round transforms for both cipher directions.
// Byte 0 of a 128-bit block lives in bits [127:120]; column c holds bytes 4c..4c+3.
package aes_pkg;

  localparam int NB = 4;
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// The last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [127:0] added;

  assign added = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
  assign next_state = final_round ? added : inv_mix_columns(added);

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Define AES_INV_KEY_LATCH_EN to capture expanded_keys at accept time.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            ciphertext,
  input  logic [128*(NR+1)-1:0]   expanded_keys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            plaintext
);

  fsm_t                  fsm;
  fsm_t                  fsm_nxt;
  logic [3:0]            rnd;
  logic [127:0]          state_q;
  logic [127:0]          round_key;
  logic [127:0]          round_out;
  logic                  accept;
  logic [128*(NR+1)-1:0] keys;

  assign accept = (fsm == IDLE) && in_valid;

`ifdef AES_INV_KEY_LATCH_EN
  logic [128*(NR+1)-1:0] key_q;

  // Snapshot the whole schedule so the source may change after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else if (accept) key_q <= expanded_keys;
  end

  assign keys = key_q;
`else
  assign keys = expanded_keys;
`endif

  // rnd reaches 0 in FINAL, so it indexes every round key directly.
  assign round_key = keys[{rnd, 7'd0} +: 128];

  aes_inv_round u_round (
    .state       (state_q),
    .round_key   (round_key),
    .final_round (fsm == FINAL),
    .next_state  (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else fsm <= fsm_nxt;
  end

  // Next-state logic; inputs outside the owning state are ignored.
  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:  if (in_valid) fsm_nxt = ROUND;
      ROUND: if (rnd == 4'd1) fsm_nxt = FINAL;
      FINAL: fsm_nxt = DONE;
      DONE:  if (out_ready) fsm_nxt = IDLE;
    endcase
  end

  // Block state and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      rnd     <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q <= ciphertext ^ expanded_keys[128*NR +: 128];
            rnd     <= 4'(NR - 1);
          end
        end
        ROUND: begin
          state_q <= round_out;
          rnd     <= rnd - 4'd1;
        end
        FINAL: state_q <= round_out;
        DONE:  ;
      endcase
    end
  end

  // Handshake outputs; plaintext is only exposed while it is final.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    plaintext = '0;
    unique case (1'b1)
      fsm == IDLE: in_ready = 1'b1;
      fsm == DONE: begin
        out_valid = 1'b1;
        plaintext = state_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, handshakes, reset.
// Expected plaintexts are queued at accept and checked on output handshake.
module tb_aes_inv_cipher;
  import aes_pkg::*;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  ciphertext;
  logic [1407:0] expanded_keys;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  plaintext;

  int n_checks;
  int n_fail;
  int cyc;
  logic [127:0] cur_exp;
  logic [127:0] exp_q[$];
  int acc_t[$];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs[2];

  aes_inv_cipher dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ciphertext    (ciphertext),
    .expanded_keys (expanded_keys),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .plaintext     (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, fail count %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sub_byte(t[31:24]), sub_byte(t[23:16]),
             sub_byte(t[15:8]), sub_byte(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    r = '0;
    for (int k = 0; k < 11; k++)
      r[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_t.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h want none", plaintext);
        end else begin
          check("plaintext", plaintext, exp_q.pop_front());
        end
      end
    end
  end

  task automatic start(input vec_t v);
    int b;
    expanded_keys = expand(v.key);
    ciphertext    = v.ct;
    cur_exp       = v.pt;
    in_valid      = 1'b1;
    b = 0;
    while (!in_ready && b < 40) begin
      @(posedge clk); #1;
      b++;
    end
    check("accept_wait", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, input logic zero_keys);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (zero_keys && lat == 1) expanded_keys = '0;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic zero_keys);
    int lat;
    start(v);
    wait_out(lat, zero_keys);
    check("latency", 128'(lat), 128'd10);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    vecs[0] = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{ct: 128'h3925841d02dc09fbdc118597196a0b32,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt: 128'h3243f6a8885a308d313198a2e0370734};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ciphertext = '0;
    expanded_keys = '0;
    cur_exp = '0;
    #3;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plaintext", plaintext, 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 2; i++) run_vec(vecs[i], 1'b0);

    // Back-to-back: next block offered while DONE is handshaking.
    acc_t.delete();
    start(vecs[0]);
    wait_out(lat, 1'b0);
    check("b2b_latency0", 128'(lat), 128'd10);
    expanded_keys = expand(vecs[1].key);
    ciphertext = vecs[1].ct;
    cur_exp = vecs[1].pt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, 1'b0);
    check("b2b_latency1", 128'(lat), 128'd10);
    @(posedge clk); #1;
    check("b2b_accepts", 128'(acc_t.size()), 128'd2);
    if (acc_t.size() == 2)
      check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);

    // Backpressure: output held, in_valid pulses ignored.
    out_ready = 1'b0;
    start(vecs[0]);
    wait_out(lat, 1'b0);
    check("bp_latency", 128'(lat), 128'd10);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      ciphertext = vecs[1].ct;
      cur_exp = '0;
      check("bp_plaintext", plaintext, vecs[0].pt);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);

    // Reset in cycle 5 of a decryption aborts it.
    start(vecs[1]);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_plaintext", plaintext, 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0], 1'b0);

`ifdef AES_INV_KEY_LATCH_EN
    run_vec(vecs[0], 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
